// File: rtl/avr_sched_pkg.sv
// Shared types and helpers for the AVR tick scheduler: FSM states, default
// sizing constants and the round-robin index wrap.
package avr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int NUM_CORES_DEF = 4;
  localparam int DIV_W_DEF     = 8;
  localparam int TIMEOUT_DEF   = 1024;

  // Wraps idx into 0..n-1; callers never pass more than 2n-1.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/avr_tick_scheduler_if.sv
// Bridge-side tick request channel: valid/ready handshake plus a done pulse.
interface avr_tick_scheduler_if #(
  parameter int CORE_W = 2
);
  logic              br_valid;
  logic [CORE_W-1:0] br_core;
  logic              br_ready;
  logic              br_done;

  modport master (output br_valid, output br_core, input br_ready, input br_done);
  modport slave  (input br_valid, input br_core, output br_ready, output br_done);
endinterface

// File: rtl/avr_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module avr_sched_rr_arb #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] grant,
  output logic         valid
);
  logic [N-1:0] mask_s;
  logic [N-1:0] hi_s;
  logic [N-1:0] sel_s;

  // Prefer requests at or above the pointer; otherwise fall back to the lowest one.
  always_comb begin
    mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (i >= int'(ptr));
    end
    hi_s  = req & mask_s;
    sel_s = (|hi_s) ? hi_s : req;
    valid = |req;
    grant = {W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      grant = sel_s[i] ? W'(i) : grant;
    end
  end
endmodule

// File: rtl/avr_tick_scheduler.sv
// Per-core clock dividers feeding a round-robin tick issuer for a shared bridge.
// Optional WAIT-state watchdog is compiled in with `define TICK_TIMEOUT_EN.
module avr_tick_scheduler
  import avr_sched_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int DIV_W     = DIV_W_DEF,
  parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [NUM_CORES*DIV_W-1:0] div,
  input  logic [NUM_CORES-1:0]       core_en,
  avr_tick_scheduler_if.master       br,
  output logic [NUM_CORES-1:0]       pending,
  output logic [NUM_CORES-1:0]       overrun,
  input  logic [NUM_CORES-1:0]       overrun_clr,
  output logic                       busy,
  output logic [31:0]                tick_cnt,
  output logic                       timeout_err
);
  logic [DIV_W-1:0]     cnt_r [NUM_CORES];
  logic [NUM_CORES-1:0] expire_s, clr_s, pending_r, overrun_r;
  logic                 hs_s, grant_vld_s, valid_r, busy_r;
  logic [CORE_W-1:0]    ptr_r, core_r, grant_s;
  logic [31:0]          tick_cnt_r;
  state_t               state_r;
`ifdef TICK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0]      to_cnt_r;
  logic                 timeout_err_r;
`endif

  avr_sched_rr_arb #(.N(NUM_CORES), .W(CORE_W)) u_arb (
    .req   (pending_r),
    .ptr   (ptr_r),
    .grant (grant_s),
    .valid (grant_vld_s)
  );

  // Divider expiry and handshake clear strobes per core.
  always_comb begin
    hs_s     = valid_r && br.br_ready;
    expire_s = {NUM_CORES{1'b0}};
    clr_s    = {NUM_CORES{1'b0}};
    for (int i = 0; i < NUM_CORES; i++) begin
      expire_s[i] = en && core_en[i] && (cnt_r[i] == {DIV_W{1'b0}});
      clr_s[i]    = hs_s && (core_r == CORE_W'(i));
    end
  end

  // Per-core down counters; a new divide value is only picked up on reload.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!rst_n) begin
        cnt_r[i] <= div[i*DIV_W +: DIV_W];
      end else if (en && core_en[i]) begin
        cnt_r[i] <= expire_s[i] ? div[i*DIV_W +: DIV_W] : (cnt_r[i] - DIV_W'(1'b1));
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // Expiry wins over a same-cycle clear; overrun set wins over overrun_clr.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= {NUM_CORES{1'b0}};
      overrun_r <= {NUM_CORES{1'b0}};
    end else begin
      pending_r <= expire_s | (pending_r & ~clr_s);
      overrun_r <= (expire_s & pending_r & ~clr_s) | (overrun_r & ~overrun_clr);
    end
  end

  // Request sequencer: IDLE picks a core, REQ holds the request, WAIT awaits done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      valid_r    <= 1'b0;
      core_r     <= {CORE_W{1'b0}};
      ptr_r      <= {CORE_W{1'b0}};
      busy_r     <= 1'b0;
      tick_cnt_r <= 32'd0;
`ifdef TICK_TIMEOUT_EN
      to_cnt_r      <= {TO_W{1'b0}};
      timeout_err_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_vld_s) begin
            core_r  <= grant_s;
            valid_r <= 1'b1;
            busy_r  <= 1'b1;
            state_r <= REQ;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        REQ: begin
          if (br.br_ready) begin
            valid_r <= 1'b0;
            ptr_r   <= CORE_W'(rr_wrap(int'(core_r) + 1, NUM_CORES));
            state_r <= WAIT;
`ifdef TICK_TIMEOUT_EN
            to_cnt_r <= {TO_W{1'b0}};
`endif
          end else begin
            valid_r <= 1'b1;
          end
        end
        WAIT: begin
          if (br.br_done) begin
            tick_cnt_r <= tick_cnt_r + 32'd1;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
`ifdef TICK_TIMEOUT_EN
          else if (to_cnt_r == TO_W'(TIMEOUT - 1)) begin
            timeout_err_r <= 1'b1;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1'b1);
          end
`else
          else begin
            state_r <= WAIT;
          end
`endif
        end
        default: begin
          state_r <= IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign br.br_valid = valid_r;
  assign br.br_core  = core_r;
  assign pending     = pending_r;
  assign overrun     = overrun_r;
  assign busy        = busy_r;
  assign tick_cnt    = tick_cnt_r;
`ifdef TICK_TIMEOUT_EN
  assign timeout_err = timeout_err_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_avr_tick_scheduler.sv
// Bench for avr_tick_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a behavioural model of the scheduling rules.
module tb_avr_tick_scheduler;
  localparam int NC = 4;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst_n, en;
  logic [NC*DW-1:0] div;
  logic [NC-1:0]  core_en, overrun_clr, pending, overrun;
  logic           busy, timeout_err;
  logic [31:0]    tick_cnt;

  always #5 clk = ~clk;

  avr_tick_scheduler_if #(.CORE_W(CW)) bus ();

  avr_tick_scheduler #(.NUM_CORES(NC), .DIV_W(DW), .CORE_W(CW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .div         (div),
    .core_en     (core_en),
    .br          (bus),
    .pending     (pending),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy),
    .tick_cnt    (tick_cnt),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  int grants[$];

  // Reference model: cycles remaining per divider, flags, and transaction phase
  int          m_cnt [NC];
  bit [NC-1:0] m_pend, m_ovr;
  int          m_phase;   // 0 idle, 1 requesting, 2 waiting for done
  int          m_core, m_ptr, m_wcnt;
  bit [31:0]   m_ticks;
  bit          m_terr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input int i);
    return int'(div[i*DW +: DW]);
  endfunction

  task automatic set_div(input int i, input int v);
    div[i*DW +: DW] = DW'(v);
  endtask

  task automatic model_next();
    bit [NC-1:0] n_pend, n_ovr;
    bit hs, ex, cl, found;
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) m_cnt[i] = div_of(i);
      m_pend = '0; m_ovr = '0; m_phase = 0; m_core = 0; m_ptr = 0;
      m_wcnt = 0; m_ticks = 0; m_terr = 0;
      return;
    end
    hs = (m_phase == 1) && bus.br_ready;
    for (int i = 0; i < NC; i++) begin
      ex = en && core_en[i] && (m_cnt[i] == 0);
      cl = hs && (m_core == i);
      if (en && core_en[i]) m_cnt[i] = ex ? div_of(i) : m_cnt[i] - 1;
      n_pend[i] = ex || (m_pend[i] && !cl);
      n_ovr[i]  = (ex && m_pend[i] && !cl) || (m_ovr[i] && !overrun_clr[i]);
    end
    case (m_phase)
      0: begin
        found = 0;
        for (int k = 0; k < NC; k++) begin
          if (!found && m_pend[(m_ptr + k) % NC]) begin
            m_core = (m_ptr + k) % NC;
            found  = 1;
          end
        end
        if (found) m_phase = 1;
      end
      1: if (bus.br_ready) begin
        m_ptr = (m_core + 1) % NC;
        m_phase = 2;
        m_wcnt = 0;
      end
      default: begin
        if (bus.br_done) begin
          m_ticks++;
          m_phase = 0;
        end
`ifdef TICK_TIMEOUT_EN
        else begin
          m_wcnt++;
          if (m_wcnt == TO) begin
            m_terr = 1;
            m_phase = 0;
          end
        end
`endif
      end
    endcase
    m_pend = n_pend;
    m_ovr  = n_ovr;
  endtask

  task automatic compare_all();
    chk("pending",     32'(pending),      32'(m_pend));
    chk("overrun",     32'(overrun),      32'(m_ovr));
    chk("br_valid",    32'(bus.br_valid), 32'(m_phase == 1));
    chk("br_core",     32'(bus.br_core),  32'(m_core));
    chk("busy",        32'(busy),         32'(m_phase != 0));
    chk("tick_cnt",    tick_cnt,          m_ticks);
    chk("timeout_err", 32'(timeout_err),  32'(m_terr));
  endtask

  task automatic step();
    if (bus.br_valid && bus.br_ready) grants.push_back(int'(bus.br_core));
    model_next();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; en = 1'b0; core_en = '0; overrun_clr = '0; div = '0;
    bus.br_ready = 1'b0; bus.br_done = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tick", tick_cnt, 32'd0);

    // div=0 everywhere, bridge always ready/done
    rst_n = 1'b1; en = 1'b1; core_en = 4'hF;
    bus.br_ready = 1'b1; bus.br_done = 1'b1;
    grants.delete();
    repeat (16) step();
    chk("s1_ngrants", 32'(grants.size()), 32'd5);
    for (int k = 0; k < 5 && k < grants.size(); k++) chk("s1_order", 32'(grants[k]), 32'(exp_order[k]));
    chk("s1_ticks", tick_cnt, 32'd5);
    chk("s1_overrun", 32'(overrun), 32'hF);
    chk("s1_pending", 32'(pending), 32'hF);

    // Stalled bridge: request must stay put
    set_div(0, 3); set_div(1, 7); set_div(2, 15); set_div(3, 31);
    bus.br_ready = 1'b0; bus.br_done = 1'b0;
    do_reset();
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      step();
      hit = bus.br_valid;
    end
    if (!hit) chk("s2_valid_timeout", 32'd0, 32'd1);
    repeat (20) begin
      step();
      chk("s2_valid_hold", 32'(bus.br_valid), 32'd1);
      chk("s2_core_hold", 32'(bus.br_core), 32'd0);
    end
    chk("s2_ovr0", 32'(overrun[0]), 32'd1);
    chk("s2_ovr3", 32'(overrun[3]), 32'd0);
    bus.br_ready = 1'b1; bus.br_done = 1'b1;
    repeat (10) step();

    // Core1 expiry coincides with its handshake
    div = '0; set_div(1, 1); core_en = 4'h2;
    bus.br_ready = 1'b1; bus.br_done = 1'b0;
    do_reset();
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      hit = bus.br_valid && bus.br_ready;
      step();
    end
    if (!hit) chk("s3_hs_timeout", 32'd0, 32'd1);
    chk("s3_pend1", 32'(pending[1]), 32'd1);
    chk("s3_ovr1", 32'(overrun[1]), 32'd0);
    bus.br_done = 1'b1;
    repeat (4) step();

    // overrun_clr racing an overrun set on core2
    div = '0; core_en = 4'h4; bus.br_ready = 1'b0; bus.br_done = 1'b0;
    do_reset();
    repeat (3) step();
    overrun_clr = 4'h4;
    step();
    chk("s4_set_wins", 32'(overrun[2]), 32'd1);
    overrun_clr = 4'h0; core_en = 4'h0;
    step();
    chk("s4_hold", 32'(overrun[2]), 32'd1);
    overrun_clr = 4'h4;
    step();
    chk("s4_cleared", 32'(overrun[2]), 32'd0);
    overrun_clr = 4'h0;

    // Reset while waiting for done
    core_en = 4'hF; bus.br_ready = 1'b1; bus.br_done = 1'b1;
    repeat (8) step();
    bus.br_done = 1'b0;
    hit = 0;
    for (int k = 0; k < 10 && !hit; k++) begin
      step();
      hit = busy && !bus.br_valid;
    end
    if (!hit) chk("s5_wait_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_valid", 32'(bus.br_valid), 32'd0);
    chk("s5_pending", 32'(pending), 32'd0);
    chk("s5_tick", tick_cnt, 32'd0);

`ifdef TICK_TIMEOUT_EN
    // Bridge never completes
    core_en = 4'h1; bus.br_ready = 1'b1; bus.br_done = 1'b0;
    do_reset();
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      hit = bus.br_valid && bus.br_ready;
      step();
    end
    if (!hit) chk("s6_hs_timeout", 32'd0, 32'd1);
    repeat (TO - 1) step();
    chk("s6_err_early", 32'(timeout_err), 32'd0);
    step();
    chk("s6_err", 32'(timeout_err), 32'd1);
    chk("s6_idle", 32'(busy), 32'd0);
    chk("s6_tick", tick_cnt, 32'd0);
`endif

    // Random traffic against the model
    for (int i = 0; i < NC; i++) set_div(i, $urandom_range(0, 6));
    core_en = 4'hF;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) core_en = NC'($urandom);
      if ($urandom_range(0, 15) == 0) set_div($urandom_range(0, NC - 1), $urandom_range(0, 6));
      overrun_clr = ($urandom_range(0, 7) == 0) ? NC'($urandom) : '0;
      bus.br_ready = 1'($urandom_range(0, 1));
      bus.br_done  = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
